// File: rtl/morse_tx.sv
// morse_tx: ASCII-to-Morse on/off keying transmitter.
// Bytes enter a synchronous FIFO over valid/ready. Each byte is looked up
// (A-Z, a-z, 0-9, space) and keyed on morse_out with ITU unit timing.
// Optional Farnsworth gap stretching is enabled by defining
// MORSE_TX_FARNSWORTH_EN, which adds the extra_gap input port.
module morse_tx #(
    parameter int UNIT_CYCLES = 100000,
    parameter int DEPTH       = 16
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
`ifdef MORSE_TX_FARNSWORTH_EN
    input  logic [3:0] extra_gap,
`endif
    output logic       morse_out,
    output logic       busy,
    output logic       char_done,
    output logic       bad_char
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(UNIT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(UNIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(UNIT_CYCLES - 2);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MARK = 3'd1,
        ST_EGAP = 3'd2,
        ST_CGAP = 3'd3,
        ST_WGAP = 3'd4
    } state_t;

    // Returns {length[2:0], pattern[4:0]}; pattern is left-aligned, MSB sent
    // first, 1 = dash. Length 0 marks an unsupported byte (space included,
    // which is handled separately).
    function automatic logic [7:0] morse_lookup(input logic [7:0] ch);
        logic [7:0] up;
        logic [7:0] code;
        if ((ch >= 8'h61) && (ch <= 8'h7A)) begin
            up = ch - 8'h20;
        end else begin
            up = ch;
        end
        case (up)
            8'h41: code = {3'd2, 5'b01000};
            8'h42: code = {3'd4, 5'b10000};
            8'h43: code = {3'd4, 5'b10100};
            8'h44: code = {3'd3, 5'b10000};
            8'h45: code = {3'd1, 5'b00000};
            8'h46: code = {3'd4, 5'b00100};
            8'h47: code = {3'd3, 5'b11000};
            8'h48: code = {3'd4, 5'b00000};
            8'h49: code = {3'd2, 5'b00000};
            8'h4A: code = {3'd4, 5'b01110};
            8'h4B: code = {3'd3, 5'b10100};
            8'h4C: code = {3'd4, 5'b01000};
            8'h4D: code = {3'd2, 5'b11000};
            8'h4E: code = {3'd2, 5'b10000};
            8'h4F: code = {3'd3, 5'b11100};
            8'h50: code = {3'd4, 5'b01100};
            8'h51: code = {3'd4, 5'b11010};
            8'h52: code = {3'd3, 5'b01000};
            8'h53: code = {3'd3, 5'b00000};
            8'h54: code = {3'd1, 5'b10000};
            8'h55: code = {3'd3, 5'b00100};
            8'h56: code = {3'd4, 5'b00010};
            8'h57: code = {3'd3, 5'b01100};
            8'h58: code = {3'd4, 5'b10010};
            8'h59: code = {3'd4, 5'b10110};
            8'h5A: code = {3'd4, 5'b11000};
            8'h30: code = {3'd5, 5'b11111};
            8'h31: code = {3'd5, 5'b01111};
            8'h32: code = {3'd5, 5'b00111};
            8'h33: code = {3'd5, 5'b00011};
            8'h34: code = {3'd5, 5'b00001};
            8'h35: code = {3'd5, 5'b00000};
            8'h36: code = {3'd5, 5'b10000};
            8'h37: code = {3'd5, 5'b11000};
            8'h38: code = {3'd5, 5'b11100};
            8'h39: code = {3'd5, 5'b11110};
            default: code = 8'h00;
        endcase
        return code;
    endfunction

    // FIFO storage and pointers (extra wrap bit distinguishes full/empty)
    logic [7:0]    mem_r [DEPTH];
    logic [AW:0]   wr_ptr_r;
    logic [AW:0]   rd_ptr_r;
    logic          empty_s;
    logic          full_s;
    logic          push_s;
    logic          pop_s;
    logic [7:0]    head_s;
    logic [7:0]    head_code_s;
    logic [2:0]    head_len_s;
    logic [4:0]    head_pat_s;
    logic          head_space_s;

    // FSM and timing state
    state_t        state_r;
    state_t        state_n;
    logic [2:0]    len_r;
    logic [4:0]    pat_r;
    logic [CW-1:0] cnt_r;
    logic [4:0]    units_r;
    logic [4:0]    dur_s;
    logic [4:0]    gap_extra_s;
    logic          tick_s;
    logic          last_unit_s;
    logic          done_s;
    logic          dispatch_s;
    logic          restart_s;
    logic          load_s;
    logic          bad_s;
    logic          morse_out_r;
    logic          char_done_r;
    logic          bad_char_r;

    assign empty_s      = (wr_ptr_r == rd_ptr_r);
    assign full_s       = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                          (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign push_s       = in_valid && !full_s;
    assign head_s       = mem_r[rd_ptr_r[AW-1:0]];
    assign head_code_s  = morse_lookup(head_s);
    assign head_len_s   = head_code_s[7:5];
    assign head_pat_s   = head_code_s[4:0];
    assign head_space_s = (head_s == 8'h20);

`ifdef MORSE_TX_FARNSWORTH_EN
    logic [3:0] extra_r;
    assign gap_extra_s = {1'b0, extra_r};
`else
    assign gap_extra_s = 5'd0;
`endif

    assign tick_s      = (cnt_r == CNT_LAST);
    assign last_unit_s = (units_r == (dur_s - 5'd1));
    assign done_s      = tick_s && last_unit_s;
    assign restart_s   = (state_n != state_r) || done_s;
    assign load_s      = pop_s && !head_space_s && (head_len_s != 3'd0);
    assign bad_s       = pop_s && !head_space_s && (head_len_s == 3'd0);

    assign in_ready  = !full_s;
    assign busy      = (state_r != ST_IDLE) || !empty_s;
    assign morse_out = morse_out_r;
    assign char_done = char_done_r;
    assign bad_char  = bad_char_r;

    // FIFO data write; storage needs no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= in_data;
        end
    end

    // FIFO pointer update; push and pop in one cycle are both honoured
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Length of the current state in units
    always_comb begin
        dur_s = 5'd1;
        case (state_r)
            ST_MARK: dur_s = pat_r[4] ? 5'd3 : 5'd1;
            ST_EGAP: dur_s = 5'd1;
            ST_CGAP: dur_s = 5'd3 + gap_extra_s;
            ST_WGAP: dur_s = 5'd4 + gap_extra_s;
            default: dur_s = 5'd1;
        endcase
    end

    // Next-state logic; gap ends dispatch the next byte directly so that
    // back-to-back characters have no idle cycle between them
    always_comb begin
        state_n    = state_r;
        pop_s      = 1'b0;
        dispatch_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                dispatch_s = 1'b1;
            end
            ST_MARK: begin
                if (done_s) begin
                    if (len_r > 3'd1) begin
                        state_n = ST_EGAP;
                    end else begin
                        state_n = ST_CGAP;
                    end
                end else begin
                    state_n = ST_MARK;
                end
            end
            ST_EGAP: begin
                if (done_s) begin
                    state_n = ST_MARK;
                end else begin
                    state_n = ST_EGAP;
                end
            end
            ST_CGAP, ST_WGAP: begin
                if (done_s) begin
                    state_n    = ST_IDLE;
                    dispatch_s = 1'b1;
                end else begin
                    state_n = state_r;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        if (dispatch_s && !empty_s) begin
            pop_s = 1'b1;
            if (head_space_s) begin
                state_n = ST_WGAP;
            end else if (head_len_s != 3'd0) begin
                state_n = ST_MARK;
            end else begin
                state_n = ST_IDLE;
            end
        end else begin
            pop_s = 1'b0;
        end
    end

    // State register plus character length/pattern shift register
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r <= ST_IDLE;
            len_r   <= 3'd0;
            pat_r   <= 5'd0;
        end else begin
            state_r <= state_n;
            if (load_s) begin
                len_r <= head_len_s;
                pat_r <= head_pat_s;
            end else if ((state_r == ST_EGAP) && done_s) begin
                len_r <= len_r - 3'd1;
                pat_r <= {pat_r[3:0], 1'b0};
            end
        end
    end

    // Unit timer: restarts on every state entry, held at zero while idle
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt_r   <= {CW{1'b0}};
            units_r <= 5'd0;
        end else if (restart_s || (state_r == ST_IDLE)) begin
            cnt_r   <= {CW{1'b0}};
            units_r <= 5'd0;
        end else if (tick_s) begin
            cnt_r   <= {CW{1'b0}};
            units_r <= units_r + 5'd1;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

`ifdef MORSE_TX_FARNSWORTH_EN
    // Capture the extra gap length on entry to a character or word gap
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            extra_r <= 4'd0;
        end else if (restart_s && ((state_n == ST_CGAP) || (state_n == ST_WGAP))) begin
            extra_r <= extra_gap;
        end
    end
`endif

    // Registered outputs: keying from next state, pulses timed to the last
    // gap cycle and to the pop of an unsupported byte
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            morse_out_r <= 1'b0;
            char_done_r <= 1'b0;
            bad_char_r  <= 1'b0;
        end else begin
            morse_out_r <= (state_n == ST_MARK);
            char_done_r <= ((state_r == ST_CGAP) || (state_r == ST_WGAP)) &&
                           last_unit_s && (cnt_r == CNT_PRE);
            bad_char_r  <= bad_s;
        end
    end

endmodule

// File: tb/tb_morse_tx.sv
// Self-checking bench for morse_tx (UNIT_CYCLES=4, DEPTH=4). The reference
// model expands each byte into its dot/dash text and then into a per-cycle
// expected waveform; FIFO occupancy is tracked as a simple counter.
module tb_morse_tx;

    localparam int U = 4;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       morse_out;
    logic       busy;
    logic       char_done;
    logic       bad_char;
`ifdef MORSE_TX_FARNSWORTH_EN
    logic [3:0] extra_gap;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int gap_x    = 0;

    string letters [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.",
                            "....", "..", ".---", "-.-", ".-..", "--", "-.",
                            "---", ".--.", "--.-", ".-.", "...", "-", "..-",
                            "...-", ".--", "-..-", "-.--", "--.."};
    string digits [10]  = '{"-----", ".----", "..---", "...--", "....-",
                            ".....", "-....", "--...", "---..", "----."};

    logic [7:0] tx_q [$];
    bit         m_q [$];
    bit         cd_q [$];
    bit         bc_q [$];
    bit         act_q [$];
    int         pop_q [$];

    morse_tx #(.UNIT_CYCLES(U), .DEPTH(D)) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
`ifdef MORSE_TX_FARNSWORTH_EN
        .extra_gap (extra_gap),
`endif
        .morse_out (morse_out),
        .busy      (busy),
        .char_done (char_done),
        .bad_char  (bad_char)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // kind: 0 unsupported, 1 letter/digit, 2 space
    task automatic classify(input logic [7:0] b, output string s, output int kind);
        s = "";
        kind = 0;
        if (b >= 8'h61 && b <= 8'h7A) begin
            s = letters[b - 8'h61]; kind = 1;
        end else if (b >= 8'h41 && b <= 8'h5A) begin
            s = letters[b - 8'h41]; kind = 1;
        end else if (b >= 8'h30 && b <= 8'h39) begin
            s = digits[b - 8'h30]; kind = 1;
        end else if (b == 8'h20) begin
            kind = 2;
        end
    endtask

    task automatic add_cycles(input int n, input bit m, input bit cd_last, input bit bc, input bit act);
        for (int i = 0; i < n; i++) begin
            m_q.push_back(m);
            cd_q.push_back(cd_last && (i == n - 1));
            bc_q.push_back(bc);
            act_q.push_back(act);
        end
    endtask

    // Expand tx_q into the expected per-cycle waveform and pop edges
    task automatic build();
        string s;
        int kind;
        m_q.delete(); cd_q.delete(); bc_q.delete(); act_q.delete(); pop_q.delete();
        for (int k = 0; k < tx_q.size(); k++) begin
            pop_q.push_back(1 + m_q.size());
            classify(tx_q[k], s, kind);
            if (kind == 0) begin
                add_cycles(1, 1'b0, 1'b0, 1'b1, 1'b0);
            end else if (kind == 2) begin
                add_cycles((4 + gap_x) * U, 1'b0, 1'b1, 1'b0, 1'b1);
            end else begin
                for (int i = 0; i < s.len(); i++) begin
                    add_cycles((s[i] == 8'h2D) ? 3 * U : U, 1'b1, 1'b0, 1'b0, 1'b1);
                    if (i < s.len() - 1) begin
                        add_cycles(U, 1'b0, 1'b0, 1'b0, 1'b1);
                    end
                end
                add_cycles((3 + gap_x) * U, 1'b0, 1'b1, 1'b0, 1'b1);
            end
        end
    endtask

    task automatic load_str(input string s);
        tx_q.delete();
        for (int i = 0; i < s.len(); i++) begin
            tx_q.push_back(s[i]);
        end
    endtask

    // Offer tx_q as a continuous burst and check every cycle; call at negedge
    task automatic run_burst(input string tag);
        int n, p, occ, t;
        bit is_pop;
        bit em, ecd, ebc, eact;
        n = tx_q.size(); p = 0; occ = 0;
        build();
        t = m_q.size();
        for (int e = 0; e <= t + 1; e++) begin
            if (p < n) begin
                in_valid = 1'b1; in_data = tx_q[p];
            end else begin
                in_valid = 1'b0; in_data = 8'h00;
            end
            check($sformatf("%s@%0d in_ready", tag, e), in_ready, occ < D);
            @(posedge clk);
            is_pop = (pop_q.size() > 0) && (pop_q[0] == e);
            if (is_pop) void'(pop_q.pop_front());
            if (in_valid && occ < D) begin
                occ++; p++;
            end
            if (is_pop) occ--;
            @(negedge clk);
            if (e >= 1 && e <= t) begin
                em = m_q[e-1]; ecd = cd_q[e-1]; ebc = bc_q[e-1]; eact = act_q[e-1];
            end else begin
                em = 1'b0; ecd = 1'b0; ebc = 1'b0; eact = 1'b0;
            end
            check($sformatf("%s@%0d morse_out", tag, e), morse_out, em);
            check($sformatf("%s@%0d char_done", tag, e), char_done, ecd);
            check($sformatf("%s@%0d bad_char", tag, e), bad_char, ebc);
            check($sformatf("%s@%0d busy", tag, e), busy, eact || (occ > 0));
        end
        in_valid = 1'b0;
    endtask

    initial begin
        string pool;
        arst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
`ifdef MORSE_TX_FARNSWORTH_EN
        extra_gap = 4'd0;
`endif
        repeat (3) @(negedge clk);
        check("rst morse_out", morse_out, 1'b0);
        check("rst char_done", char_done, 1'b0);
        check("rst bad_char", bad_char, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst in_ready", in_ready, 1'b1);
        arst_n = 1'b1;
        @(negedge clk);

        load_str("E");        run_burst("E");
        load_str("a");        run_burst("a");
        load_str("A");        run_burst("A");
        load_str("A B");      run_burst("A_B");
        load_str("00000000"); run_burst("zeros");
        load_str("#T");       run_burst("badT");

        pool = "AEIMNOSTUVX0159 eqz#*~";
        for (int r = 0; r < 3; r++) begin
            tx_q.delete();
            for (int i = 0; i < 5; i++) begin
                tx_q.push_back(pool[$urandom_range(0, pool.len() - 1)]);
            end
            run_burst($sformatf("rand%0d", r));
        end

`ifdef MORSE_TX_FARNSWORTH_EN
        gap_x = 2; extra_gap = 4'd2;
`endif
        load_str("EE");       run_burst("EE");
`ifdef MORSE_TX_FARNSWORTH_EN
        gap_x = 0; extra_gap = 4'd0;
`endif

        // Reset in the middle of a 'T' dash with 'E' still queued
        in_valid = 1'b1; in_data = 8'h54;
        @(posedge clk); @(negedge clk);
        in_data = 8'h45;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0; in_data = 8'h00;
        repeat (5) @(negedge clk);
        check("mid-dash morse_out", morse_out, 1'b1);
        check("mid-dash busy", busy, 1'b1);
        arst_n = 1'b0;
        #1;
        check("async rst morse_out", morse_out, 1'b0);
        check("async rst in_ready", in_ready, 1'b1);
        check("async rst busy", busy, 1'b0);
        check("async rst char_done", char_done, 1'b0);
        @(negedge clk);
        arst_n = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            check($sformatf("post-rst@%0d morse_out", i), morse_out, 1'b0);
            check($sformatf("post-rst@%0d busy", i), busy, 1'b0);
            check($sformatf("post-rst@%0d char_done", i), char_done, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/morse_tx.md
# morse_tx

Parametrised, single-clock ASCII-to-Morse transmitter and successor to the current Morse output block. Characters arrive over a valid/ready byte interface into an internal synchronous FIFO. They are converted to Morse elements and serialised on one on/off keying output with ITU timing: dot 1 unit, dash 3 units, element gap 1 unit, character gap 3 units, word gap 7 units. The unit length, FIFO depth, unsupported-character reporting and optional Farnsworth spacing are new.

## Interface
- UNIT_CYCLES, 100000: clk cycles per Morse unit; ≥2.
- DEPTH, 16: FIFO entries; power of 2, ≥2.
- clk  input  1  sole clock; all logic on rising edge.
- arst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- in_valid  input  1  byte offered.
- in_data  input  8  ASCII byte.
- in_ready  output  1  FIFO not full; a byte is accepted on an edge with in_valid && in_ready.
- morse_out  output  1  keying output, 1 = tone.
- busy  output  1  FIFO non-empty or FSM not IDLE.
- char_done  output  1  one-cycle pulse at end of each character gap or word gap.
- bad_char  output  1  one-cycle pulse when an unsupported byte is popped.
- extra_gap  input  4  extra units per character/word gap. Present only with MORSE_TX_FARNSWORTH_EN.

## Operation
- Reset values:
  - morse_out=0, char_done=0, bad_char=0, busy=0, in_ready=1.
  - FIFO emptied, FSM in IDLE, unit timer cleared.
- FIFO: synchronous, DEPTH entries, read/write pointers with a wrap bit.
  - No write when full; in_ready is low.
  - Push and pop in the same cycle are both honoured.
- Lookup, combinational on the FIFO head: 3-bit length (1..5) plus 5-bit pattern, MSB first, 1 = dash.
  - Supported: A–Z, a–z (case-folded), 0–9, and space (0x20).
  - All other bytes are unsupported.
- Unit timer: counts 0..UNIT_CYCLES-1 and asserts tick on the terminal count.
  - Restarted to 0 on every state transition, so each state lasts exactly N×UNIT_CYCLES clocks.
- FSM states:
  - IDLE: when the FIFO is non-empty, pop the head and register length/pattern.
    - Letter/digit → MARK.
    - Space → WGAP.
    - Unsupported → pulse bad_char and stay IDLE; next pop may follow on the next cycle.
  - MARK: morse_out=1 for 1 unit (dot) or 3 units (dash).
    - If elements remain → EGAP.
    - Otherwise → CGAP.
  - EGAP: morse_out=0 for 1 unit; shift pattern, decrement length, → MARK.
  - CGAP: morse_out=0 for 3 units (+extra_gap); pulse char_done on the last cycle, → IDLE.
  - WGAP: morse_out=0 for 4 units (+extra_gap); pulse char_done on the last cycle, → IDLE.
    - A space after a character therefore yields the 7-unit word gap.
- morse_out is a registered output, decoded from the next state.
- busy = (state != IDLE) || !empty.

## Timing
- Byte accepted on edge N into an empty FIFO with FSM in IDLE:
  - Pop occurs on edge N+1.
  - morse_out rises on edge N+1.
- Dot is high exactly UNIT_CYCLES clocks; dash is high exactly 3×UNIT_CYCLES clocks.
- Back-to-back characters: the next MARK begins on the edge after the char_done cycle, with no idle cycles.
- Bytes arriving during transmission are queued; byte order is preserved.
- Boundary cases:
  - When full, in_ready deasserts combinationally from the pointers and reasserts the cycle after a pop.
  - A pop while full with in_valid high does not accept that cycle's byte.
- arst_n assertion mid-character: morse_out drops immediately (asynchronously), queued bytes are lost, and no char_done is produced.
- extra_gap is sampled on entry to CGAP/WGAP; changes mid-gap are ignored.

## Configuration
- MORSE_TX_FARNSWORTH_EN defined:
  - Port extra_gap exists.
  - CGAP lasts 3+extra_gap units and WGAP lasts 4+extra_gap units (5-bit gap counter).
- MORSE_TX_FARNSWORTH_EN undefined:
  - Port absent.
  - CGAP fixed at 3 units, WGAP fixed at 4 units.

## Test plan
- UNIT_CYCLES=4: push 'E' → morse_out rises one edge after acceptance, high 4 clocks, low 12 clocks; char_done pulses on the 12th low clock; busy falls on the following cycle.
- Push 'a' (0x61) → high 4, low 4, high 12, low 12; waveform identical to 'A'.
- Push "A B" back-to-back → A pattern, then low 3+4=7 units (28 clocks), then B pattern; 3 char_done pulses.
- DEPTH=4: push 8 bytes of '0' continuously with in_valid=1 → in_ready low when 4 entries are queued, re-high one cycle after each pop; all 8 characters transmitted in order.
- Push '#', 'T' → bad_char pulse one cycle after '#' accepted, no output for '#'; 'T' dash begins on the following edge.
- Reset mid-dash of 'T' with 'E' queued → morse_out 0 immediately, in_ready=1, busy=0; no output after reset release.
- With MORSE_TX_FARNSWORTH_EN and extra_gap=2: push "EE" → low gap between the two dots is 5 units (20 clocks).
